word_alu_pipe: RTL and testbench
================================

WORD_ALU_PIPE -- requirements
Module: word_alu_pipe

Interface
REQ-001 Parameter FLAG_CHAIN, default 1: when 1, the Z result for ADC/SBC is chained with z_in (AVR CPC/SBC semantics); when 0, Z reflects the result only.
REQ-002 Port cp2, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port flush, input, 1: synchronous clear of both pipeline stages.
REQ-005 Port in_valid, input, 1: upstream operand set valid.
REQ-006 Port in_ready, output, 1: block can accept an operand set this cycle.
REQ-007 Port op, input, 2: operation select; 00 ADD, 01 ADC, 10 SUB, 11 SBC.
REQ-008 Port a_in, input, 16: operand A.
REQ-009 Port b_in, input, 16: operand B.
REQ-010 Port c_in, input, 1: incoming carry/borrow flag; used only by ADC/SBC.
REQ-011 Port z_in, input, 1: incoming zero flag; used only by ADC/SBC when FLAG_CHAIN=1.
REQ-012 Port out_valid, output, 1: result and flags valid.
REQ-013 Port out_ready, input, 1: downstream consumes the result this cycle.
REQ-014 Port s_out, output, 16: registered result.
REQ-015 Port flags_out, output, 6: {H,S,V,N,Z,C}, with C in bit 0.

Function
REQ-016 Pipeline: stage 1 registers op/a/b/c_in/z_in; stage 2 registers the sum and flags; each stage has its own valid bit.
REQ-017 Accept condition: accept when in_valid && in_ready. in_ready = !s1_valid || s1_moves; s1_moves = s1_valid && (!s2_valid || out_ready).
REQ-018 Latency: a set accepted in cycle N appears with out_valid=1 at cycle N+2 if not stalled. Throughput is 1 per cycle with out_ready held high.
REQ-019 Backpressure: while out_valid && !out_ready, s_out, flags_out and stage-2 contents are held stable; stage 1 fills and then deasserts in_ready. No data is dropped or duplicated.
REQ-020 Arithmetic (17-bit sum, bit 16 = raw carry):
  - ADD: A+B+0.
  - ADC: A+B+c_in.
  - SUB: A+~B+1.
  - SBC: A+~B+~c_in.
REQ-021 C flag: for ADD/ADC, C = raw carry; for SUB/SBC, C = ~raw carry (borrow).
REQ-022 H flag: carry (add) or borrow (sub) out of bit 3, using the same inversion rule as C.
REQ-023 N flag = s[15].
REQ-024 V flag = two's-complement overflow of the effective operands A and B' (B' = B or ~B): (A15==B'15) && (s15!=A15).
REQ-025 S flag = N^V.
REQ-026 Z flag:
  - ADD/SUB, or FLAG_CHAIN=0: Z = (s==0).
  - ADC/SBC with FLAG_CHAIN=1: Z = (s==0) && z_in_registered.
REQ-027 Flush: when flush=1, both valid bits clear at the next edge and no input is accepted that cycle; flush takes priority over simultaneous accept and consume. s_out/flags_out data registers need not clear.
REQ-028 Wrap-around: 0xFFFF+0x0001 ADD gives s=0x0000 with C=1 and Z=1. Modulo-2^16 results are never saturated.

Reset
REQ-029 While rst=1 (asynchronous, independent of cp2): s1_valid=0, s2_valid=0, out_valid=0, s_out=0x0000, flags_out=6'b000000. in_ready=1 once rst deasserts.
REQ-030 Reset asserted mid-operation discards all in-flight sets. The first accept after rst deassertion behaves as from idle.

Verification
REQ-031 ADD a=0x7FFF b=0x0001, out_ready=1 -> after 2 cycles, s=0x8000, V=1, N=1, S=0, H=1, C=0, Z=0.
REQ-032 SUB a=0x0000 b=0x0001 -> s=0xFFFF, C=1, N=1, V=0, S=1, Z=0. Then SBC a=0x0001 b=0x0000 c_in=1 z_in=1 -> s=0x0000, Z=1, C=0.
REQ-033 SBC result 0x0000 with z_in=0, FLAG_CHAIN=1 -> Z=0. The same stimulus with FLAG_CHAIN=0 -> Z=1.
REQ-034 Stream 5 sets back-to-back while out_ready is held 0 for cycles 3-6 -> in_ready drops after 2 sets are buffered, outputs are held stable, all 5 results emerge in order, and none are lost or repeated.
REQ-035 flush asserted together with in_valid=1 and both stages full -> next cycle out_valid=0, nothing is accepted, and in_ready=1.
REQ-036 rst pulsed asynchronously between clock edges with 2 sets in flight -> outputs are immediately 0 with out_valid=0, and no stale result appears afterward.

Source files
------------

// File: rtl/word_alu_pipe.sv
// Purpose: two-stage 16-bit add/subtract unit (ADD/ADC/SUB/SBC) producing the result and AVR-style {H,S,V,N,Z,C} flags.
// Latency: 2 cycles from accept to out_valid; throughput 1 set per cycle while out_ready stays high.
// Backpressure: valid/ready; a stalled stage 2 holds its outputs, stage 1 fills, then in_ready drops. flush clears both stages.
//
// Ports:
//   cp2, rst              clock (rising edge), asynchronous active-high reset
//   flush                 synchronous clear of both pipeline valid bits
//   in_valid / in_ready   upstream handshake for {op, a_in, b_in, c_in, z_in}
//   op                    00 ADD, 01 ADC, 10 SUB, 11 SBC
//   c_in, z_in            incoming carry/borrow and zero flags (ADC/SBC only)
//   out_valid / out_ready downstream handshake for s_out / flags_out
//   s_out                 registered 16-bit result
//   flags_out             registered {H,S,V,N,Z,C}, C in bit 0
module word_alu_pipe #(
    parameter bit FLAG_CHAIN = 1'b1
) (
    input  logic        cp2,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic        c_in,
    input  logic        z_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] s_out,
    output logic [5:0]  flags_out
);

    // Operand set captured by stage 1.
    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        z;
    } opnd_t;

    // Flag vector in output bit order {H,S,V,N,Z,C}.
    typedef struct packed {
        logic h;
        logic s;
        logic v;
        logic n;
        logic z;
        logic c;
    } flags_t;

    opnd_t       s1_dat;
    logic        s1_vld;
    logic        s2_vld;
    logic        s1_moves;
    logic        accept;
    logic        consume;

    logic        is_sub;
    logic        use_c;
    logic [15:0] b_eff;
    logic        cin_eff;
    logic [16:0] sum17;
    logic [4:0]  lo5;
    logic        res_zero;
    flags_t      fl_nxt;

    // Handshake: stage 1 drains into stage 2 whenever stage 2 is empty or
    // being consumed; stage 1 can take a new set when it is empty or draining.
    always_comb begin
        s1_moves = s1_vld && (!s2_vld || out_ready);
        in_ready = !s1_vld || s1_moves;
        accept   = in_valid && in_ready && !flush;
        consume  = s2_vld && out_ready;
    end

    // Stage 1: operand register.
    always_ff @(posedge cp2 or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else if (flush) begin
            s1_vld <= 1'b0;
        end else if (accept) begin
            s1_vld   <= 1'b1;
            s1_dat.op <= op;
            s1_dat.a  <= a_in;
            s1_dat.b  <= b_in;
            s1_dat.c  <= c_in;
            s1_dat.z  <= z_in;
        end else if (s1_moves) begin
            s1_vld <= 1'b0;
        end
    end

    // Arithmetic on the stage-1 operands. Subtraction is A + ~B + carry-in,
    // so the raw carries come out inverted relative to a borrow; C and H
    // undo that inversion for SUB/SBC.
    always_comb begin
        is_sub   = s1_dat.op[1];
        use_c    = s1_dat.op[0];
        b_eff    = is_sub ? ~s1_dat.b : s1_dat.b;
        cin_eff  = use_c ? (s1_dat.c ^ is_sub) : is_sub;
        sum17    = {1'b0, s1_dat.a} + {1'b0, b_eff} + {16'd0, cin_eff};
        lo5      = {1'b0, s1_dat.a[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, cin_eff};
        res_zero = (sum17[15:0] == 16'd0);

        fl_nxt   = '0;
        fl_nxt.c = sum17[16] ^ is_sub;
        fl_nxt.h = lo5[4] ^ is_sub;
        fl_nxt.n = sum17[15];
        fl_nxt.v = (s1_dat.a[15] == b_eff[15]) && (sum17[15] != s1_dat.a[15]);
        fl_nxt.s = fl_nxt.n ^ fl_nxt.v;
        // Multi-word compare/subtract: a zero high word only counts as zero
        // if the lower words were zero too.
        if (FLAG_CHAIN && use_c) begin
            fl_nxt.z = res_zero && s1_dat.z;
        end else begin
            fl_nxt.z = res_zero;
        end
    end

    // Stage 2: result register. Data only changes when a new set arrives,
    // so a stalled output stays stable.
    always_ff @(posedge cp2 or posedge rst) begin
        if (rst) begin
            s2_vld    <= 1'b0;
            s_out     <= 16'd0;
            flags_out <= 6'd0;
        end else if (flush) begin
            s2_vld <= 1'b0;
        end else if (s1_moves) begin
            s2_vld    <= 1'b1;
            s_out     <= sum17[15:0];
            flags_out <= fl_nxt;
        end else if (consume) begin
            s2_vld <= 1'b0;
        end
    end

    assign out_valid = s2_vld;

endmodule

// File: tb/tb_word_alu_pipe.sv
// Purpose: directed self-checking bench for word_alu_pipe (chained and unchained Z variants side by side).
// Latency: drives a set, expects it on out_valid two edges later.
// Backpressure: exercises out_ready stalls, flush with full pipeline, and asynchronous reset mid-flight.
module tb_word_alu_pipe;

    logic        cp2;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        c_in;
    logic        z_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s_out;
    logic [5:0]  flags_out;

    logic        in_ready_nc;
    logic        out_valid_nc;
    logic [15:0] s_out_nc;
    logic [5:0]  flags_out_nc;

    int checks = 0;
    int errors = 0;

    word_alu_pipe #(.FLAG_CHAIN(1'b1)) dut (
        .cp2       (cp2),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .flags_out (flags_out)
    );

    word_alu_pipe #(.FLAG_CHAIN(1'b0)) dut_nc (
        .cp2       (cp2),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_nc),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .z_in      (z_in),
        .out_valid (out_valid_nc),
        .out_ready (out_ready),
        .s_out     (s_out_nc),
        .flags_out (flags_out_nc)
    );

    initial cp2 = 1'b0;
    always #5 cp2 = ~cp2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One isolated transaction with out_ready high; starts 1 time unit after an edge.
    task automatic run_one(input string tag, input logic [1:0] o, input logic [15:0] a,
                           input logic [15:0] b, input logic c, input logic z,
                           input logic [15:0] es, input logic [5:0] ef, input logic [5:0] efn);
        op = o; a_in = a; b_in = b; c_in = c; z_in = z;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, in_ready, 1);
        @(posedge cp2); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        @(posedge cp2); #1;
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_s"}, s_out, es);
        chk({tag, "_f"}, flags_out, ef);
        chk({tag, "_s_nc"}, s_out_nc, es);
        chk({tag, "_f_nc"}, flags_out_nc, efn);
        @(posedge cp2); #1;
        chk({tag, "_drain"}, out_valid, 0);
    endtask

    logic [15:0] sexp [5];
    int  sent;
    int  recv;
    int  occ;
    int  cyc;
    bit  acc;
    bit  cons;
    bit  saw_block;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; a_in = 16'd0; b_in = 16'd0; c_in = 1'b0; z_in = 1'b0;

        // Reset state
        #12;
        chk("rst_vld", out_valid, 0);
        chk("rst_s", s_out, 16'h0000);
        chk("rst_f", flags_out, 6'b000000);
        rst = 1'b0;
        @(posedge cp2); #1;
        chk("rst_rdy", in_ready, 1);

        // Directed arithmetic vectors: tag, op, a, b, c, z, s, flags(chain), flags(no chain)
        run_one("add_ovf",  2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 6'b101100, 6'b101100);
        run_one("sub_neg",  2'b10, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 6'b110101, 6'b110101);
        run_one("sbc_z1",   2'b11, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0000, 6'b000010, 6'b000010);
        run_one("sbc_z0",   2'b11, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0000, 6'b000000, 6'b000010);
        run_one("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 6'b100011, 6'b100011);
        run_one("adc_c1",   2'b01, 16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5556, 6'b000000, 6'b000000);
        run_one("sub_eq",   2'b10, 16'h5555, 16'h5555, 1'b1, 1'b0, 16'h0000, 6'b000010, 6'b000010);
        run_one("sbc_ovf",  2'b11, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 6'b111000, 6'b111000);
        run_one("add_noc",  2'b00, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002, 6'b000000, 6'b000000);
        run_one("adc_zch",  2'b01, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 6'b100001, 6'b100011);

        // Stream of 5 sets with out_ready low during cycles 3..6
        for (int i = 0; i < 5; i++) sexp[i] = 16'h0011 + 16'(i);
        sent = 0; recv = 0; occ = 0; cyc = 0; saw_block = 1'b0;
        while (recv < 5 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 5);
            op = 2'b00; a_in = 16'h0010 + 16'(sent); b_in = 16'h0001; c_in = 1'b0; z_in = 1'b0;
            #1;
            chk("strm_rdy", in_ready, ((occ < 2) || out_ready) ? 1 : 0);
            if (!in_ready) saw_block = 1'b1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (out_valid) chk("strm_dat", s_out, sexp[recv]);
            if (cons) recv++;
            if (acc) sent++;
            occ = occ + (acc ? 1 : 0) - (cons ? 1 : 0);
            @(posedge cp2); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("strm_cnt", recv, 5);
        chk("strm_blk", saw_block, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge cp2); #1;
            chk("strm_nodup", out_valid, 0);
        end

        // Flush with both stages full and a new set offered
        out_ready = 1'b0;
        op = 2'b00; a_in = 16'h0100; b_in = 16'h0001; in_valid = 1'b1;
        @(posedge cp2); #1;
        a_in = 16'h0200;
        @(posedge cp2); #1;
        chk("fl_full_vld", out_valid, 1);
        chk("fl_full_rdy", in_ready, 0);
        a_in = 16'h0300; flush = 1'b1; out_ready = 1'b1;
        @(posedge cp2); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_vld", out_valid, 0);
        chk("fl_rdy", in_ready, 1);
        @(posedge cp2); #1;
        chk("fl_noacc", out_valid, 0);

        // Asynchronous reset between edges with 2 sets in flight
        out_ready = 1'b0;
        op = 2'b00; a_in = 16'h7FFF; b_in = 16'h0001; in_valid = 1'b1;
        @(posedge cp2); #1;
        a_in = 16'h1234;
        @(posedge cp2); #1;
        in_valid = 1'b0;
        chk("ar_pre_vld", out_valid, 1);
        chk("ar_pre_s", s_out, 16'h8000);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_vld", out_valid, 0);
        chk("ar_s", s_out, 16'h0000);
        chk("ar_f", flags_out, 6'b000000);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge cp2); #1;
        chk("ar_rdy", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("ar_nostale", out_valid, 0);
            @(posedge cp2); #1;
        end
        run_one("ar_fresh", 2'b10, 16'h0010, 16'h0001, 1'b0, 1'b0, 16'h000F, 6'b100000, 6'b100000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
